// File: rtl/systolic_row_feeder_if.sv
// systolic_row_feeder_if: job control, upstream vector stream and West-edge array bus
// Ports (slave = feeder side):
//   start, num_vec, abort     job control into the feeder
//   in_valid, in_ready        upstream row-vector handshake
//   in_data                   upstream vector, lane r = [r*DATA_W +: DATA_W]
//   pe_data                   West data_in of every row, one lane per row
//   pe_load_w, pe_enable      global array controls
//   busy, done                feeder status
interface systolic_row_feeder_if #(
    parameter int ROWS   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
);
    logic                   start;
    logic [CNT_W-1:0]       num_vec;
    logic                   abort;
    logic                   in_valid;
    logic                   in_ready;
    logic [ROWS*DATA_W-1:0] in_data;
    logic [ROWS*DATA_W-1:0] pe_data;
    logic                   pe_load_w;
    logic                   pe_enable;
    logic                   busy;
    logic                   done;
    modport master (
        output start, num_vec, abort, in_valid, in_data,
        input  in_ready, pe_data, pe_load_w, pe_enable, busy, done
    );
    modport slave (
        input  start, num_vec, abort, in_valid, in_data,
        output in_ready, pe_data, pe_load_w, pe_enable, busy, done
    );
endinterface

// File: rtl/systolic_row_feeder.sv
// systolic_row_feeder: loads COLS weight beats, streams num_vec diagonally skewed pixel vectors, then drains
// Ports:
//   clk    clock
//   rst_n  asynchronous active-low reset
//   bus    systolic_row_feeder_if.slave: job control, upstream stream, West-edge array outputs
module systolic_row_feeder #(
    parameter int ROWS   = 4,
    parameter int COLS   = 4,
    parameter int DATA_W = 8,
    parameter int CNT_W  = 16
) (
    input logic clk,
    input logic rst_n,
    systolic_row_feeder_if.slave bus
);
    localparam int DRAIN_LEN = ROWS + COLS + 2;
    typedef enum logic [1:0] {IDLE, LOAD_W, STREAM, DRAIN} state_t;
    state_t                 r_state, w_next;
    logic [CNT_W-1:0]       r_cnt, r_nv, w_lim;
    logic                   w_acc, w_go, w_step, w_last, w_shift;
    logic [ROWS*DATA_W-1:0] w_in, w_skewed;
    assign bus.in_ready = r_state == LOAD_W || r_state == STREAM;
    assign bus.busy     = r_state != IDLE;
    assign w_acc        = bus.in_valid && bus.in_ready;
    assign w_go         = r_state == IDLE && bus.start && !bus.abort;
    // one step per accepted beat while feeding, one per cycle while draining
    assign w_step       = w_acc || r_state == DRAIN;
    assign w_lim        = r_state == LOAD_W ? CNT_W'(COLS - 1) :
                          r_state == STREAM ? r_nv - CNT_W'(1) : CNT_W'(DRAIN_LEN - 1);
    assign w_last       = w_step && r_cnt == w_lim;
    assign w_shift      = !bus.abort && ((r_state == STREAM && w_acc) || r_state == DRAIN);
    // drain pushes zeros into lane 0 and the skew lines
    assign w_in         = r_state == DRAIN ? '0 : bus.in_data;
    always_comb begin
        w_next = r_state;
        if (bus.abort)
            w_next = IDLE;
        else if (w_go)
            w_next = LOAD_W;
        else if (w_last)
            w_next = r_state == LOAD_W ? (r_nv == '0 ? DRAIN : STREAM) :
                     r_state == STREAM ? DRAIN : IDLE;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_state <= IDLE;
        else
            r_state <= w_next;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= '0;
            r_nv  <= '0;
        end else if (bus.abort) begin
            r_cnt <= '0;
        end else if (w_go) begin
            r_cnt <= '0;
            r_nv  <= bus.num_vec;
        end else if (w_step) begin
            r_cnt <= w_last ? '0 : r_cnt + CNT_W'(1);
        end
    end
    genvar g;
    generate
        for (g = 0; g < ROWS; g++) begin : g_lane
            if (g == 0) begin : g_direct
                assign w_skewed[DATA_W-1:0] = w_in[DATA_W-1:0];
            end else begin : g_skew
                // lane g is delayed by g accepted beats; the line only moves on a shift
                logic [DATA_W-1:0] r_sk [g];
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        for (int i = 0; i < g; i++) r_sk[i] <= '0;
                    end else if (w_go) begin
                        for (int i = 0; i < g; i++) r_sk[i] <= '0;
                    end else if (w_shift) begin
                        r_sk[0] <= w_in[g*DATA_W +: DATA_W];
                        for (int i = 1; i < g; i++) r_sk[i] <= r_sk[i-1];
                    end
                end
                assign w_skewed[g*DATA_W +: DATA_W] = r_sk[g-1];
            end
        end
    endgenerate
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.pe_enable <= 1'b0;
            bus.pe_load_w <= 1'b0;
            bus.pe_data   <= '0;
            bus.done      <= 1'b0;
        end else begin
            bus.pe_enable <= !bus.abort && w_step;
            bus.pe_load_w <= !bus.abort && w_acc && r_state == LOAD_W;
            bus.pe_data   <= (bus.abort || !w_step) ? '0 :
                             r_state == LOAD_W ? bus.in_data : w_skewed;
            bus.done      <= !bus.abort && w_last && r_state == DRAIN;
        end
    end
endmodule
